// File: rtl/uart_tx_controller_if.sv
// SRAM read-port bundle between the UART dump controller and the buffer SRAM.
// Handshake: the controller pulses sram_start low for one cycle with
// sram_addr valid; the SRAM later holds sram_ready high with sram_rdata valid.
// The first cycle after the strobe may still show the previous ready state.
interface uart_tx_controller_if;
  logic        sram_ready;
  logic [15:0] sram_rdata;
  logic [15:0] sram_addr;
  logic        sram_rw;
  logic        sram_start;

  modport master (
    input  sram_ready,
    input  sram_rdata,
    output sram_addr,
    output sram_rw,
    output sram_start
  );

  modport slave (
    output sram_ready,
    output sram_rdata,
    input  sram_addr,
    input  sram_rw,
    input  sram_start
  );
endinterface

// File: rtl/uart_tx_controller.sv
// Dumps SRAM bytes 0..last_addr over a UART TX line (8N1) after a switch pulse.
// One byte per SRAM read: strobe, wait for ready, shift out 10 bits, advance.
module uart_tx_controller #(
  parameter int clk_per_bit = 87,
  parameter int last_addr   = 1001
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_switch,
  uart_tx_controller_if.master         bus,
  output logic                         o_uart_out,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_overrun,
  output logic [2:0]                   o_state
);

  localparam int CW = (clk_per_bit > 1) ? $clog2(clk_per_bit) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(clk_per_bit - 1);
  localparam logic [15:0]   ADDR_LAST = 16'(last_addr);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    NEXT = 3'd4
  } state_t;

  state_t        r_state;
  logic [15:0]   r_addr;
  logic          r_start;
  logic          r_uart;
  logic          r_busy;
  logic          r_done;
  logic          r_overrun;
  logic          r_wait_first;
  logic [7:0]    r_shift;
  logic [CW-1:0] r_bit_cnt;
  logic [3:0]    r_bit_idx;

  // Only the low byte of the SRAM word is transmitted.
  logic w_unused_rdata_hi;
  assign w_unused_rdata_hi = ^bus.sram_rdata[15:8];

  // A switch while a dump is running, or in the cycle done is shown, is refused.
  logic w_switch_blocked;
  assign w_switch_blocked = r_busy | r_done;

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= 16'd0;
      r_start      <= 1'b1;
      r_uart       <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_wait_first <= 1'b0;
      r_shift      <= 8'd0;
      r_bit_cnt    <= '0;
      r_bit_idx    <= 4'd0;
    end else begin
      r_done <= 1'b0;
      if (i_switch && w_switch_blocked) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (i_switch && !w_switch_blocked) begin
            r_addr  <= 16'd0;
            r_busy  <= 1'b1;
            r_start <= 1'b0;
            r_state <= REQ;
          end
        end
        REQ: begin
          // Strobe was low for this single cycle; release it.
          r_start      <= 1'b1;
          r_wait_first <= 1'b1;
          r_state      <= WAIT;
        end
        WAIT: begin
          // First WAIT cycle may still carry a stale ready from the SRAM.
          if (r_wait_first) begin
            r_wait_first <= 1'b0;
          end else if (bus.sram_ready) begin
            r_shift   <= bus.sram_rdata[7:0];
            r_uart    <= 1'b0;
            r_bit_cnt <= '0;
            r_bit_idx <= 4'd0;
            r_state   <= SEND;
          end
        end
        SEND: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == 4'd9) begin
              r_uart    <= 1'b1;
              r_bit_idx <= 4'd0;
              r_state   <= NEXT;
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
              // Bit index k+1 carries data bit k; index 9 is the stop bit.
              r_uart    <= (r_bit_idx < 4'd8) ? r_shift[r_bit_idx[2:0]] : 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (r_addr == ADDR_LAST) begin
            r_addr  <= 16'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_addr  <= r_addr + 16'd1;
            r_start <= 1'b0;
            r_state <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sram_addr  = r_addr;
  assign bus.sram_rw    = 1'b1;
  assign bus.sram_start = r_start;
  assign o_uart_out     = r_uart;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_overrun      = r_overrun;
  assign o_state        = r_state;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Bench for uart_tx_controller with clk_per_bit=4, last_addr=3.
module tb_uart_tx_controller;
  localparam int CPB   = 4;
  localparam int LAST  = 3;
  localparam int FRAME = 10 * CPB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw  = 1'b0;
  always #5 clk = ~clk;

  logic       uart, busy, done, overrun;
  logic [2:0] dbg_state;

  uart_tx_controller_if bus ();

  uart_tx_controller #(.clk_per_bit(CPB), .last_addr(LAST)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_switch   (sw),
    .bus        (bus),
    .o_uart_out (uart),
    .o_busy     (busy),
    .o_done     (done),
    .o_overrun  (overrun),
    .o_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_addr_q[$];
  logic [7:0]  mem [4];
  int lat        = 2;
  int stall_addr = -1;
  int stall_len  = 0;
  int done_cnt   = 0;
  int strobe_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- SRAM model ----------------
  // One stale-ready cycle after the strobe, then ready low until the latency
  // expires, then ready high with the addressed byte and random upper bits.
  int         sram_cnt = 0;
  int         sram_lat = 2;
  logic [1:0] sram_raddr = 2'd0;
  always @(negedge clk) begin
    if (rst) begin
      bus.sram_ready = 1'b1;
      bus.sram_rdata = 16'h0000;
      sram_cnt       = 0;
    end else begin
      if (sram_cnt > 0) begin
        sram_cnt--;
        if (sram_cnt == 0) begin
          bus.sram_ready = 1'b1;
          bus.sram_rdata = {8'($urandom), mem[sram_raddr]};
        end else if (sram_cnt == sram_lat - 1) begin
          bus.sram_ready = 1'b1;
          bus.sram_rdata = 16'($urandom);
        end else begin
          bus.sram_ready = 1'b0;
          bus.sram_rdata = 16'($urandom);
        end
      end
      if (bus.sram_start === 1'b0) begin
        sram_raddr = bus.sram_addr[1:0];
        sram_lat   = lat + ((int'(bus.sram_addr) == stall_addr) ? stall_len : 0);
        sram_cnt   = sram_lat;
      end
    end
  end

  // ---------------- monitors ----------------
  logic             p_uart  = 1'b1;
  logic             p_start = 1'b1;
  logic             p_busy  = 1'b0;
  logic             cap     = 1'b0;
  int               cap_n   = 0;
  logic [FRAME-1:0] obs;
  logic [FRAME-1:0] exp_wave;
  logic [9:0]       exp_frame;

  always @(negedge clk) begin
    if (rst) begin
      cap = 1'b0;
    end else begin
      // UART frame capture: 40 samples from the falling edge of the start bit.
      if (cap) begin
        obs[cap_n] = uart;
        cap_n++;
        if (cap_n == FRAME) begin
          cap = 1'b0;
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            exp_frame = {1'b1, exp_q.pop_front(), 1'b0};
            for (int c = 0; c < FRAME; c++) exp_wave[c] = exp_frame[c / CPB];
            check("frame_wave", obs, exp_wave);
          end
        end
      end else if (uart === 1'b0 && p_uart === 1'b1) begin
        cap    = 1'b1;
        obs    = '0;
        obs[0] = 1'b0;
        cap_n  = 1;
      end
      // Read strobes: one cycle wide, in address order.
      if (bus.sram_start === 1'b0) begin
        strobe_cnt++;
        check("strobe_len", p_start, 1);
        check("strobe_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) check("strobe_addr", bus.sram_addr, exp_addr_q.pop_front());
      end
      // done is a pulse and busy drops in the same cycle.
      if (done === 1'b1) begin
        done_cnt++;
        check("busy_falls_with_done", {p_busy, busy}, 2'b10);
      end
    end
    p_uart  = uart;
    p_start = bus.sram_start;
    p_busy  = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_switch();
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
  endtask

  task automatic queue_dump();
    for (int i = 0; i <= LAST; i++) begin
      exp_q.push_back(mem[i]);
      exp_addr_q.push_back(16'(i));
    end
  endtask

  task automatic random_mem();
    for (int i = 0; i <= LAST; i++) mem[i] = 8'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int start_cnt = done_cnt;
    int n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_cnt != start_cnt, 1);
  endtask

  task automatic wait_strobe(input logic [15:0] a, input int budget);
    int n = 0;
    while (!(bus.sram_start === 1'b0 && bus.sram_addr === a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("strobe_reached", n < budget, 1);
  endtask

  task automatic wait_uart_low(input int budget);
    int n = 0;
    while (uart !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("start_bit_reached", n < budget, 1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(2);
    check("rst_uart", uart, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_start", bus.sram_start, 1);
    check("rst_addr", bus.sram_addr, 0);
    check("rst_rw", bus.sram_rw, 1);
    exp_q.delete();
    exp_addr_q.delete();
    rst = 1'b0;
    tick(2);
  endtask

  task automatic end_of_dump(input int d0, input int s0);
    tick(5);
    check("bytes_all_sent", exp_q.size(), 0);
    check("addrs_all_read", exp_addr_q.size(), 0);
    check("done_once", done_cnt - d0, 1);
    check("four_strobes", strobe_cnt - s0, LAST + 1);
    check("idle_busy", busy, 0);
    check("idle_uart", uart, 1);
  endtask

  task automatic full_dump(input int budget);
    int d0 = done_cnt;
    int s0 = strobe_cnt;
    queue_dump();
    pulse_switch();
    wait_done(budget);
    end_of_dump(d0, s0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int d0, s0, n;
    logic bad;
    tick(1);
    reset_dut();
    tick(10);
    check("no_start_without_switch", strobe_cnt, 0);

    // Basic dump of fixed bytes.
    mem[0] = 8'h55; mem[1] = 8'hA3; mem[2] = 8'h00; mem[3] = 8'hFF;
    lat = 2;
    full_dump(1000);
    check("no_overrun_basic", overrun, 0);

    // Bit timing with 0x01 in the first slot.
    random_mem();
    mem[0] = 8'h01;
    full_dump(1000);

    // SRAM stall at address 2.
    random_mem();
    stall_addr = 2;
    stall_len  = 50;
    d0 = done_cnt;
    s0 = strobe_cnt;
    queue_dump();
    pulse_switch();
    wait_strobe(16'd2, 1000);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (uart !== 1'b1 || bus.sram_addr !== 16'd2) bad = 1'b1;
    end
    check("stall_holds_line_and_addr", bad, 0);
    wait_done(2000);
    end_of_dump(d0, s0);
    stall_addr = -1;
    stall_len  = 0;

    // Overrun: switch during frame 1.
    random_mem();
    d0 = done_cnt;
    s0 = strobe_cnt;
    queue_dump();
    pulse_switch();
    wait_uart_low(500);
    tick(3);
    pulse_switch();
    check("overrun_set", overrun, 1);
    wait_done(1000);
    tick(100);
    end_of_dump(d0, s0);
    check("overrun_sticky", overrun, 1);

    reset_dut();
    check("overrun_cleared", overrun, 0);

    // Switch in the same cycle as done.
    random_mem();
    d0 = done_cnt;
    s0 = strobe_cnt;
    queue_dump();
    pulse_switch();
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", n < 1000, 1);
    pulse_switch();
    tick(100);
    end_of_dump(d0, s0);
    check("overrun_on_done", overrun, 1);

    reset_dut();

    // Reset during the data bits of byte 1 (all-zero data keeps the line low).
    random_mem();
    mem[1] = 8'h00;
    queue_dump();
    pulse_switch();
    wait_strobe(16'd1, 1000);
    wait_uart_low(500);
    tick(6);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_rst_uart", uart, 1);
    check("midframe_rst_busy", busy, 0);
    check("midframe_rst_addr", bus.sram_addr, 0);
    check("midframe_rst_start", bus.sram_start, 1);
    exp_q.delete();
    exp_addr_q.delete();
    rst = 1'b0;
    s0 = strobe_cnt;
    tick(50);
    check("no_restart_after_rst", strobe_cnt - s0, 0);
    check("idle_after_rst_uart", uart, 1);
    random_mem();
    full_dump(1000);

    // Randomized dumps with varying SRAM latency.
    for (int k = 0; k < 4; k++) begin
      random_mem();
      lat = $urandom_range(2, 6);
      full_dump(2000);
    end
    check("final_no_overrun", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_controller.md
UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 Parameter clk_per_bit, default 87: clk cycles per UART bit.
REQ-002 Parameter last_addr, default 1001: final SRAM address read per dump.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 switch  in  1  one-cycle pulse: a filled buffer is ready; start a dump.
REQ-007 sram_ready  in  1  SRAM idle/read complete.
REQ-008 sram_rdata  in  16  SRAM read data; only [7:0] is used.
REQ-009 sram_addr  out  16  SRAM read address.
REQ-010 sram_rw  out  1  constant 1 (read).
REQ-011 sram_start  out  1  active-low one-cycle read request strobe.
REQ-012 uart_out  out  1  serial TX line, idle high.
REQ-013 busy  out  1  high from accepted switch until dump completes.
REQ-014 done  out  1  one-cycle pulse after last byte's stop bit.
REQ-015 overrun  out  1  sticky: switch arrived while busy.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, SEND, NEXT.
REQ-017 IDLE: on switch=1, set sram_addr=0 and busy=1, and go to REQ the next cycle.
REQ-018 REQ: drive sram_start=0 for exactly one cycle, then go to WAIT.
REQ-019 WAIT: ignore sram_ready in its first cycle; from the second cycle on, when sram_ready=1, latch sram_rdata[7:0] into the shift register and go to SEND.
REQ-020 SEND: transmit a start bit (0), 8 data bits LSB first, then a stop bit (1), each held exactly clk_per_bit cycles; the frame is 10*clk_per_bit cycles.
REQ-021 The start bit SHALL appear on uart_out the cycle after the WAIT->SEND transition.
REQ-022 NEXT: if sram_addr==last_addr, set sram_addr=0, busy=0, pulse done=1 one cycle, go to IDLE; else increment sram_addr by 1 and go to REQ.
REQ-023 sram_addr SHALL be 16-bit unsigned and never exceed last_addr.
REQ-024 uart_out SHALL be 1 in every state other than SEND.
REQ-025 switch while busy=1 SHALL be ignored for control and SHALL set overrun=1, which stays set until rst.
REQ-026 switch coincident with done SHALL be treated as arriving while busy: overrun set, no new dump.
REQ-027 A stalled sram_ready SHALL hold the block in WAIT indefinitely, with no timeout.
REQ-028 The bit counter SHALL count 0..clk_per_bit-1 and wrap; the bit index SHALL count 0..9.

Reset
REQ-029 rst=1 at any clock edge SHALL force: IDLE, sram_addr=0, sram_start=1, uart_out=1, busy=0, done=0, overrun=0, counters=0.
REQ-030 Reset mid-frame SHALL abort the frame immediately; uart_out returns high on the next cycle, with no partial stop bit.
REQ-031 After reset release, the block SHALL wait for a fresh switch pulse.

Verification (clk_per_bit=4, last_addr=3)
REQ-032 Basic dump: SRAM holds 0x55, 0xA3, 0x00, 0xFF at addresses 0-3 and sram_ready responds 2 cycles after the strobe; pulse switch -> four 40-cycle frames decode to 55, A3, 00, FF; sram_start shows 4 low pulses at addresses 0, 1, 2, 3; done pulses once; busy falls with done.
REQ-033 Bit timing: byte 0x01 -> uart_out is 0 for 4 cycles, 1 for 4 cycles, 0 for 28 cycles, then 1 for 4 cycles.
REQ-034 SRAM stall: hold sram_ready=0 for 50 cycles at address 2 -> uart_out stays high, sram_addr stays 2, and the dump resumes correctly.
REQ-035 Overrun: pulse switch again during frame 1 -> overrun=1, dump still sends exactly 4 bytes, no second dump starts.
REQ-036 Reset mid-operation: assert rst during the data bits of byte 1 -> the next cycle shows uart_out=1, busy=0, sram_addr=0, sram_start=1; a later switch gives a clean full dump from address 0.
